// File: rtl/uart_status_tx.sv
// Status reporter: sends "S<hh> P<hhhh>\r\n" as 8N1 UART whenever state/score
// change or on request; changes arriving mid-line collapse into one follow-up line.
//
// state | meaning
// IDLE  | line idle high, waiting for a trigger or a pending follow-up
// START | start bit (low) for one baud period
// DATA  | 8 data bits, LSB first
// STOP  | stop bit (high); advances to next byte or ends the line
module uart_status_tx #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115_200
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [7:0]  state,
  input  logic [15:0] score,
  input  logic        send_req,
  output logic        uart_tx,
  output logic        busy,
  output logic        done
);

  localparam int BAUD_DIV = CLK_HZ / BAUD;
  localparam int CW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_DIV - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} fsm_t;

  fsm_t          fsm_q, fsm_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    idx_q, idx_d;
  logic [7:0]    last_state_q, last_state_d;
  logic [15:0]   last_score_q, last_score_d;
  logic          pending_q, pending_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          changed, trigger, wrap;
  logic [7:0]    cur_byte;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // The snapshot registers double as the line buffer.
  function automatic logic [7:0] line_byte(input logic [3:0] idx, input logic [7:0] st,
                                           input logic [15:0] sc);
    case (idx)
      4'd0:    return 8'h53;
      4'd1:    return hex_ascii(st[7:4]);
      4'd2:    return hex_ascii(st[3:0]);
      4'd3:    return 8'h20;
      4'd4:    return 8'h50;
      4'd5:    return hex_ascii(sc[15:12]);
      4'd6:    return hex_ascii(sc[11:8]);
      4'd7:    return hex_ascii(sc[7:4]);
      4'd8:    return hex_ascii(sc[3:0]);
      4'd9:    return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  always_comb begin
    changed      = {state, score} != {last_state_q, last_score_q};
    trigger      = send_req | changed;
    wrap         = (cnt_q == CNT_LAST);
    fsm_d        = fsm_q;
    cnt_d        = cnt_q;
    bit_d        = bit_q;
    idx_d        = idx_q;
    last_state_d = last_state_q;
    last_score_d = last_score_q;
    pending_d    = pending_q;
    done_d       = 1'b0;

    case (fsm_q)
      IDLE: begin
        cnt_d = '0;
        bit_d = '0;
        idx_d = '0;
        if (trigger || pending_q) begin
          last_state_d = state;
          last_score_d = score;
          pending_d    = 1'b0;
          fsm_d        = START;
        end
      end
      START: if (wrap) begin
        fsm_d = DATA;
        bit_d = '0;
      end
      DATA: if (wrap) begin
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) fsm_d = STOP;
      end
      STOP: if (wrap) begin
        if (idx_q == 4'd10) begin
          fsm_d  = IDLE;
          idx_d  = '0;
          done_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
          fsm_d = START;
        end
      end
      default: fsm_d = IDLE;
    endcase

    if (fsm_q != IDLE) begin
      cnt_d = wrap ? '0 : cnt_q + 1'b1;
      if (trigger) pending_d = 1'b1;
    end

    // Output is registered from next-state values so uart_tx is glitch-free.
    cur_byte = line_byte(idx_d, last_state_d, last_score_d);
    busy_d   = (fsm_d != IDLE);
    case (fsm_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = cur_byte[bit_d];
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q        <= IDLE;
      cnt_q        <= '0;
      bit_q        <= '0;
      idx_q        <= '0;
      last_state_q <= '0;
      last_score_q <= '0;
      pending_q    <= 1'b0;
      tx_q         <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      fsm_q        <= fsm_d;
      cnt_q        <= cnt_d;
      bit_q        <= bit_d;
      idx_q        <= idx_d;
      last_state_q <= last_state_d;
      last_score_q <= last_score_d;
      pending_q    <= pending_d;
      tx_q         <= tx_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign uart_tx = tx_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_uart_status_tx.sv
// Bench for uart_status_tx: decodes the serial line at a small baud divisor and
// compares each line against the text the status values should produce.
module tb_uart_status_tx;

  localparam int CLK_HZ = 1_000_000;
  localparam int BAUD   = 76_923;
  localparam int DIV    = 13;  // 1e6 / 76923 truncated

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [7:0]  state = 8'h00;
  logic [15:0] score = 16'h0000;
  logic        send_req = 1'b0;
  logic        uart_tx, busy, done;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  uart_status_tx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk(clk), .reset_n(reset_n), .state(state), .score(score),
    .send_req(send_req), .uart_tx(uart_tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (done === 1'b1) done_cnt++;

  // Expected line text, built from a hex-digit lookup string.
  function automatic logic [87:0] exp_line(input logic [7:0] st, input logic [15:0] sc);
    string hexd;
    byte   b[11];
    logic [87:0] v;
    hexd = "0123456789ABCDEF";
    b[0] = 8'h53; b[1] = hexd[int'(st[7:4])]; b[2] = hexd[int'(st[3:0])];
    b[3] = 8'h20; b[4] = 8'h50;
    b[5] = hexd[int'(sc[15:12])]; b[6] = hexd[int'(sc[11:8])];
    b[7] = hexd[int'(sc[7:4])];   b[8] = hexd[int'(sc[3:0])];
    b[9] = 8'h0D; b[10] = 8'h0A;
    v = '0;
    for (int i = 0; i < 11; i++) v[87-8*i -: 8] = b[i];
    return v;
  endfunction

  // Called just after the edge that starts a line. Samples 110*DIV cycles,
  // then the done cycle. ok clears on unstable bits, bad framing, busy low
  // mid-line, or a missing done/busy-drop right after the last stop bit.
  task automatic receive_line(output logic [87:0] got, output bit ok);
    logic v;
    bit   stable;
    ok  = 1'b1;
    got = '0;
    for (int i = 0; i < 11; i++) begin
      for (int s = 0; s < 10; s++) begin
        stable = 1'b1;
        v = 1'bx;
        for (int c = 0; c < DIV; c++) begin
          @(negedge clk);
          if (c == 0) v = uart_tx;
          else if (uart_tx !== v) stable = 1'b0;
          if (busy !== 1'b1 || done !== 1'b0) ok = 1'b0;
        end
        if (!stable) ok = 1'b0;
        if (s == 0 && v !== 1'b0) ok = 1'b0;
        if (s == 9 && v !== 1'b1) ok = 1'b0;
        if (s >= 1 && s <= 8) got[79-8*i+s] = v;
      end
    end
    @(negedge clk);
    if (done !== 1'b1 || busy !== 1'b0 || uart_tx !== 1'b1) ok = 1'b0;
  endtask

  task automatic kick(input logic [7:0] st, input logic [15:0] sc, input logic req);
    @(posedge clk); #1;
    state = st; score = sc; send_req = req;
    @(posedge clk); #1;
    send_req = 1'b0;
  endtask

  task automatic test_reset;
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx, busy, done} !== 3'b100) begin
      errors++; $display("FAIL reset_async got tx/busy/done=%b want 100", {uart_tx, busy, done});
    end
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({uart_tx, busy, done} !== 3'b100) begin
      errors++; $display("FAIL reset_release got tx/busy/done=%b want 100", {uart_tx, busy, done});
    end
  endtask

  task automatic test_idle;
    bit quiet = 1'b1;
    int d0 = done_cnt;
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      if (uart_tx !== 1'b1 || busy !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL idle_line got quiet=%0b want 1", quiet);
    end
    checks++;
    if (done_cnt - d0 !== 0) begin
      errors++; $display("FAIL idle_done got %0d pulses want 0", done_cnt - d0);
    end
  endtask

  task automatic test_basic;
    logic [87:0] got;
    bit ok;
    kick(8'h03, 16'h1234, 1'b1);
    receive_line(got, ok);
    checks++;
    if (got !== 88'h53_30_33_20_50_31_32_33_34_0D_0A) begin
      errors++; $display("FAIL basic_bytes got %h want 5330332050313233340d0a", got);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL basic_timing got ok=%0b want 1", ok);
    end
    @(negedge clk);
    checks++;
    if ({busy, uart_tx} !== 2'b01) begin
      errors++; $display("FAIL basic_after got busy/tx=%b want 01", {busy, uart_tx});
    end
  endtask

  task automatic test_hex_letters;
    logic [87:0] got;
    bit ok;
    kick(8'hA5, 16'hBEEF, 1'b0);
    receive_line(got, ok);
    checks++;
    if (got !== 88'h53_41_35_20_50_42_45_45_46_0D_0A) begin
      errors++; $display("FAIL hex_bytes got %h want 5341352050424545460d0a", got);
    end
    checks++;
    if (ok !== 1'b1) begin
      errors++; $display("FAIL hex_timing got ok=%0b want 1", ok);
    end
  endtask

  task automatic test_random;
    logic [87:0] got;
    bit ok;
    logic [7:0]  st;
    logic [15:0] sc;
    logic        req;
    for (int n = 0; n < 4; n++) begin
      st  = 8'($urandom);
      sc  = 16'($urandom);
      req = 1'($urandom_range(0, 1));
      if (st == state && sc == score) req = 1'b1;
      kick(st, sc, req);
      receive_line(got, ok);
      checks++;
      if (got !== exp_line(st, sc) || ok !== 1'b1) begin
        errors++;
        $display("FAIL random_line%0d got %h ok=%0b want %h ok=1", n, got, ok, exp_line(st, sc));
      end
    end
  endtask

  task automatic test_collapse;
    logic [87:0] g1, g2;
    bit ok1, ok2;
    bit quiet = 1'b1;
    kick(8'h3C, 16'h0001, 1'b0);
    fork
      receive_line(g1, ok1);
      begin
        repeat (32*DIV) @(negedge clk);
        score = 16'h0002;
        repeat (DIV) @(negedge clk);
        score = 16'h0003;
      end
    join
    receive_line(g2, ok2);
    checks++;
    if (g1 !== exp_line(8'h3C, 16'h0001) || ok1 !== 1'b1) begin
      errors++; $display("FAIL collapse_first got %h ok=%0b want %h ok=1", g1, ok1, exp_line(8'h3C, 16'h0001));
    end
    checks++;
    if (g2 !== exp_line(8'h3C, 16'h0003) || ok2 !== 1'b1) begin
      errors++; $display("FAIL collapse_follow got %h ok=%0b want %h ok=1", g2, ok2, exp_line(8'h3C, 16'h0003));
    end
    for (int c = 0; c < 3*DIV; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || uart_tx !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL collapse_no_third got quiet=%0b want 1", quiet);
    end
  endtask

  task automatic test_reset_mid;
    logic [87:0] got;
    bit ok;
    kick(8'h5C, 16'h0F0F, 1'b1);
    repeat (53*DIV + 4) @(negedge clk);
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL midreset_inflight got busy=%b want 1", busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({uart_tx, busy, done} !== 3'b100) begin
      errors++; $display("FAIL midreset_async got tx/busy/done=%b want 100", {uart_tx, busy, done});
    end
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;
    receive_line(got, ok);
    checks++;
    if (got !== exp_line(8'h5C, 16'h0F0F) || ok !== 1'b1) begin
      errors++; $display("FAIL midreset_fresh got %h ok=%0b want %h ok=1", got, ok, exp_line(8'h5C, 16'h0F0F));
    end
  endtask

  task automatic test_req_at_done;
    logic [87:0] g1, g2;
    bit ok1, ok2;
    bit quiet = 1'b1;
    kick(8'h77, 16'h4321, 1'b1);
    receive_line(g1, ok1);
    send_req = 1'b1;
    @(posedge clk); #1;
    send_req = 1'b0;
    receive_line(g2, ok2);
    checks++;
    if (g1 !== exp_line(8'h77, 16'h4321) || ok1 !== 1'b1) begin
      errors++; $display("FAIL reqdone_first got %h ok=%0b want %h ok=1", g1, ok1, exp_line(8'h77, 16'h4321));
    end
    checks++;
    if (g2 !== exp_line(8'h77, 16'h4321) || ok2 !== 1'b1) begin
      errors++; $display("FAIL reqdone_second got %h ok=%0b want %h ok=1", g2, ok2, exp_line(8'h77, 16'h4321));
    end
    for (int c = 0; c < 3*DIV; c++) begin
      @(negedge clk);
      if (busy !== 1'b0 || uart_tx !== 1'b1) quiet = 1'b0;
    end
    checks++;
    if (quiet !== 1'b1) begin
      errors++; $display("FAIL reqdone_no_third got quiet=%0b want 1", quiet);
    end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_hex_letters();
    test_random();
    test_collapse();
    test_reset_mid();
    test_req_at_done();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
